// File: rtl/ppl_exit.sv
// Ray-march exit stage. A single slot register holds the ray that just left
// the march pipeline. The slot either recirculates the ray to the pipeline
// entry or retires it into a small FWFT write queue for the framebuffer.
module ppl_exit #(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int MAX_STEPS  = 63,
  parameter int WORLD_SIZE = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [19:0]        in_pixel_addr,
  input  logic [15:0]        in_pos_x,
  input  logic [15:0]        in_pos_y,
  input  logic [15:0]        in_pos_z,
  input  logic signed [15:0] in_slope_x,
  input  logic signed [15:0] in_slope_y,
  input  logic signed [15:0] in_slope_z,
  input  logic [5:0]         in_block_cnt,
  input  logic               in_hit,
  input  logic [3:0]         in_block_id,
  input  logic [2:0]         in_face,
  output logic               stall,
  output logic               next_en,
  output logic [19:0]        pixel_addr_out,
  output logic [15:0]        end_pos_x,
  output logic [15:0]        end_pos_y,
  output logic [15:0]        end_pos_z,
  output logic signed [15:0] ray_slope_out_x,
  output logic signed [15:0] ray_slope_out_y,
  output logic signed [15:0] ray_slope_out_z,
  output logic [5:0]         block_cnt_out,
  output logic               ray_valid_out,
  output logic               fb_wr_valid,
  output logic [19:0]        fb_wr_addr,
  output logic [15:0]        fb_wr_data,
  input  logic               fb_wr_ready,
  output logic               frame_done,
  output logic [19:0]        pixel_cnt
);

  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int FRAME_PIX = H_DISP * V_DISP;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] px, py, pz;
    logic [15:0] sx, sy, sz;
    logic [5:0]  cnt;
    logic        hit;
    logic [3:0]  id;
    logic [2:0]  face;
  } ray_t;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  ray_t          slot_q, slot_d, in_ray;
  logic          slot_v_q, slot_v_d;
  wr_t           mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   pix_q, pix_d;
  logic          retire, fifo_full, fifo_empty, push, pop, last_pix;
  wr_t           push_word;

  // Wrap-around pointer increment so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Retire decision, queue handshake and backpressure.
  always_comb begin
    in_ray     = '{addr: in_pixel_addr, px: in_pos_x, py: in_pos_y, pz: in_pos_z,
                   sx: in_slope_x, sy: in_slope_y, sz: in_slope_z, cnt: in_block_cnt,
                   hit: in_hit, id: in_block_id, face: in_face};
    retire     = slot_v_q && (slot_q.hit
                 || (slot_q.cnt == 6'(MAX_STEPS))
                 || (32'(slot_q.px) >= 32'(WORLD_SIZE))
                 || (32'(slot_q.py) >= 32'(WORLD_SIZE))
                 || (32'(slot_q.pz) >= 32'(WORLD_SIZE)));
    fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    pop        = !fifo_empty && fb_wr_ready;
    // A full queue still accepts a push when its head leaves this cycle.
    stall      = retire && fifo_full && !pop;
    push       = retire && !stall;
    push_word  = '{addr: slot_q.addr,
                   data: {slot_q.hit, slot_q.face, slot_q.id, slot_q.cnt, 2'b00}};
    last_pix   = (pix_q == 20'(FRAME_PIX - 1));
  end

  // Next-state for slot, queue pointers/occupancy and frame pixel counter.
  always_comb begin
    slot_d   = slot_q;
    slot_v_d = slot_v_q;
    if (!stall) begin
      slot_v_d = in_valid;
      if (in_valid) slot_d = in_ray;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    pix_d = pix_q;
    if (push) pix_d = last_pix ? '0 : pix_q + 20'd1;
  end

  // State registers; reset drops the slot and any queued writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      slot_v_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pix_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      slot_v_q <= slot_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pix_q    <= pix_d;
    end
  end

  // Queue storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  // Outputs; data buses are zeroed whenever their valid is low.
  always_comb begin
    ray_valid_out   = slot_v_q && !retire;
    next_en         = !stall && !ray_valid_out;
    pixel_addr_out  = ray_valid_out ? slot_q.addr : '0;
    end_pos_x       = ray_valid_out ? slot_q.px : '0;
    end_pos_y       = ray_valid_out ? slot_q.py : '0;
    end_pos_z       = ray_valid_out ? slot_q.pz : '0;
    ray_slope_out_x = ray_valid_out ? slot_q.sx : '0;
    ray_slope_out_y = ray_valid_out ? slot_q.sy : '0;
    ray_slope_out_z = ray_valid_out ? slot_q.sz : '0;
    block_cnt_out   = ray_valid_out ? slot_q.cnt + 6'd1 : '0;
    fb_wr_valid     = !fifo_empty;
    fb_wr_addr      = fifo_empty ? '0 : mem_q[rd_ptr_q].addr;
    fb_wr_data      = fifo_empty ? '0 : mem_q[rd_ptr_q].data;
    frame_done      = push && last_pix;
    pixel_cnt       = pix_q;
  end

endmodule

// File: tb/tb_ppl_exit.sv
// Bench for ppl_exit: directed scenarios plus a randomized run against a
// queue-based reference model. Frame size is shrunk so wraps fit the run.
module tb_ppl_exit;
  localparam int H = 8, V = 4, FRAME = H * V, DEPTH = 4;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] px, py, pz;
    logic [15:0] sx, sy, sz;
    logic [5:0]  cnt;
    logic        hit;
    logic [3:0]  id;
    logic [2:0]  face;
  } ray_t;

  logic clk = 1'b0, rst, in_valid, in_hit, fb_wr_ready;
  logic [19:0] in_pixel_addr, pixel_addr_out, fb_wr_addr, pixel_cnt;
  logic [15:0] in_pos_x, in_pos_y, in_pos_z, end_pos_x, end_pos_y, end_pos_z, fb_wr_data;
  logic signed [15:0] in_slope_x, in_slope_y, in_slope_z;
  logic signed [15:0] ray_slope_out_x, ray_slope_out_y, ray_slope_out_z;
  logic [5:0] in_block_cnt, block_cnt_out;
  logic [3:0] in_block_id;
  logic [2:0] in_face;
  logic stall, next_en, ray_valid_out, fb_wr_valid, frame_done;

  int checks = 0, errors = 0;

  // reference model state
  bit          m_slot_v;
  ray_t        m_slot;
  logic [35:0] m_q[$];
  int          m_pcnt;

  ppl_exit #(.H_DISP(H), .V_DISP(V), .MAX_STEPS(63), .WORLD_SIZE(4096), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel_addr(in_pixel_addr),
    .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_pos_z(in_pos_z),
    .in_slope_x(in_slope_x), .in_slope_y(in_slope_y), .in_slope_z(in_slope_z),
    .in_block_cnt(in_block_cnt), .in_hit(in_hit), .in_block_id(in_block_id), .in_face(in_face),
    .stall(stall), .next_en(next_en), .pixel_addr_out(pixel_addr_out),
    .end_pos_x(end_pos_x), .end_pos_y(end_pos_y), .end_pos_z(end_pos_z),
    .ray_slope_out_x(ray_slope_out_x), .ray_slope_out_y(ray_slope_out_y),
    .ray_slope_out_z(ray_slope_out_z), .block_cnt_out(block_cnt_out),
    .ray_valid_out(ray_valid_out), .fb_wr_valid(fb_wr_valid), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .fb_wr_ready(fb_wr_ready), .frame_done(frame_done),
    .pixel_cnt(pixel_cnt)
  );

  always #5 clk = ~clk;

  function automatic ray_t mk(input logic [19:0] a, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] z, input logic [5:0] c, input logic h,
                              input logic [3:0] id, input logic [2:0] f);
    ray_t r;
    r.addr = a; r.px = x; r.py = y; r.pz = z;
    r.sx = 16'h0123; r.sy = 16'hFF00; r.sz = 16'h8001;
    r.cnt = c; r.hit = h; r.id = id; r.face = f;
    return r;
  endfunction

  function automatic ray_t rnd_ray();
    ray_t r;
    r.addr = 20'($urandom_range(0, 20'hFFFFF));
    r.px = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 65535)) : 16'($urandom_range(0, 4095));
    r.py = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 65535)) : 16'($urandom_range(0, 4095));
    r.pz = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 65535)) : 16'($urandom_range(0, 4095));
    r.sx = 16'($urandom); r.sy = 16'($urandom); r.sz = 16'($urandom);
    r.cnt = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
    r.hit = ($urandom_range(0, 2) == 0);
    r.id = 4'($urandom_range(0, 15));
    r.face = 3'($urandom_range(0, 5));
    return r;
  endfunction

  // A ray leaves when it hit, ran out of steps, or left the world cube.
  function automatic bit retires(input ray_t r);
    return r.hit || (r.cnt == 6'd63) || (r.px >= 16'd4096) || (r.py >= 16'd4096) || (r.pz >= 16'd4096);
  endfunction

  function automatic logic [15:0] word(input ray_t r);
    return {r.hit, r.face, r.id, r.cnt, 2'b00};
  endfunction

  task automatic model_reset();
    m_slot_v = 0; m_slot = '0; m_q.delete(); m_pcnt = 0;
  endtask

  task automatic model_step(input logic v, input ray_t r, input logic rdy);
    bit ret, pop, stl;
    ret = m_slot_v && retires(m_slot);
    pop = (m_q.size() > 0) && rdy;
    stl = ret && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (ret && !stl) begin
      m_q.push_back({m_slot.addr, word(m_slot)});
      m_pcnt = (m_pcnt + 1) % FRAME;
    end
    if (!stl) begin m_slot_v = v; m_slot = r; end
  endtask

  // Drive one cycle's inputs mid-cycle; outputs are observed 1ns later.
  task automatic cyc(input logic v, input ray_t r, input logic rdy);
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_pixel_addr = r.addr;
    in_pos_x = r.px; in_pos_y = r.py; in_pos_z = r.pz;
    in_slope_x = r.sx; in_slope_y = r.sy; in_slope_z = r.sz;
    in_block_cnt = r.cnt; in_hit = r.hit; in_block_id = r.id; in_face = r.face;
    fb_wr_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    fb_wr_ready = 1'b1;
    do_reset();
    checks++; if ({stall, frame_done, fb_wr_valid, ray_valid_out, next_en} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctrl got %b want 00001", {stall, frame_done, fb_wr_valid, ray_valid_out, next_en}); end
    checks++; if ({pixel_cnt, fb_wr_addr, fb_wr_data} !== 56'd0) begin
      errors++; $display("FAIL reset_fb got cnt=%0d addr=%h data=%h want 0", pixel_cnt, fb_wr_addr, fb_wr_data); end
    checks++; if ({pixel_addr_out, end_pos_x, end_pos_y, end_pos_z, ray_slope_out_x, ray_slope_out_y,
                   ray_slope_out_z, block_cnt_out} !== 122'd0) begin
      errors++; $display("FAIL reset_ray got addr=%h cnt=%0d want 0", pixel_addr_out, block_cnt_out); end
  endtask

  task automatic test_hit();
    do_reset();
    cyc(1, mk(20'd5, 16'd10, 16'd10, 16'd10, 6'd7, 1'b1, 4'd3, 3'd2), 1);
    cyc(0, '0, 1);
    checks++; if ({next_en, ray_valid_out, fb_wr_valid} !== 3'b100) begin
      errors++; $display("FAIL hit_slot got next_en=%b rvo=%b fbv=%b want 1 0 0", next_en, ray_valid_out, fb_wr_valid); end
    cyc(0, '0, 1);
    checks++; if ({fb_wr_valid, fb_wr_addr, fb_wr_data} !== {1'b1, 20'd5, 16'hA31C}) begin
      errors++; $display("FAIL hit_write got v=%b addr=%0d data=%h want 1 5 a31c", fb_wr_valid, fb_wr_addr, fb_wr_data); end
    checks++; if (next_en !== 1'b1 || pixel_cnt !== 20'd1) begin
      errors++; $display("FAIL hit_cnt got next_en=%b cnt=%0d want 1 1", next_en, pixel_cnt); end
    cyc(0, '0, 1);
    checks++; if (fb_wr_valid !== 1'b0) begin
      errors++; $display("FAIL hit_drain got fbv=%b want 0", fb_wr_valid); end
  endtask

  task automatic test_recirc();
    ray_t r;
    do_reset();
    r = mk(20'd77, 16'd100, 16'd200, 16'd300, 6'd10, 1'b0, 4'd1, 3'd1);
    cyc(1, r, 1);
    cyc(0, '0, 1);
    checks++; if ({ray_valid_out, next_en, block_cnt_out, fb_wr_valid} !== {1'b1, 1'b0, 6'd11, 1'b0}) begin
      errors++; $display("FAIL recirc_ctrl got rvo=%b next_en=%b cnt=%0d fbv=%b want 1 0 11 0",
                          ray_valid_out, next_en, block_cnt_out, fb_wr_valid); end
    checks++; if ({pixel_addr_out, end_pos_x, end_pos_y, end_pos_z, ray_slope_out_x, ray_slope_out_y, ray_slope_out_z}
                  !== {r.addr, r.px, r.py, r.pz, r.sx, r.sy, r.sz}) begin
      errors++; $display("FAIL recirc_data got addr=%0d pos=%0d,%0d,%0d want 77 100,200,300",
                          pixel_addr_out, end_pos_x, end_pos_y, end_pos_z); end
    cyc(0, '0, 1);
    checks++; if ({ray_valid_out, next_en} !== 2'b01) begin
      errors++; $display("FAIL recirc_empty got rvo=%b next_en=%b want 0 1", ray_valid_out, next_en); end
  endtask

  task automatic test_limits();
    do_reset();
    cyc(1, mk(20'd9, 16'd1, 16'd2, 16'd3, 6'd63, 1'b0, 4'd0, 3'd0), 1);
    cyc(1, mk(20'd10, 16'd5, 16'd4096, 16'd5, 6'd0, 1'b0, 4'd2, 3'd1), 1);
    checks++; if ({ray_valid_out, next_en} !== 2'b01) begin
      errors++; $display("FAIL step_retire got rvo=%b next_en=%b want 0 1", ray_valid_out, next_en); end
    cyc(1, mk(20'd11, 16'd4095, 16'd4095, 16'd4095, 6'd62, 1'b0, 4'd0, 3'd0), 1);
    checks++; if ({ray_valid_out, fb_wr_valid, fb_wr_addr, fb_wr_data} !== {1'b0, 1'b1, 20'd9, 16'h00FC}) begin
      errors++; $display("FAIL step_write got rvo=%b v=%b addr=%0d data=%h want 0 1 9 00fc",
                          ray_valid_out, fb_wr_valid, fb_wr_addr, fb_wr_data); end
    cyc(0, '0, 1);
    checks++; if ({fb_wr_valid, fb_wr_addr, fb_wr_data} !== {1'b1, 20'd10, 16'h1200}) begin
      errors++; $display("FAIL bound_write got v=%b addr=%0d data=%h want 1 10 1200", fb_wr_valid, fb_wr_addr, fb_wr_data); end
    checks++; if ({ray_valid_out, block_cnt_out, end_pos_x} !== {1'b1, 6'd63, 16'd4095}) begin
      errors++; $display("FAIL edge_recirc got rvo=%b cnt=%0d x=%0d want 1 63 4095", ray_valid_out, block_cnt_out, end_pos_x); end
    cyc(0, '0, 1);
    checks++; if (fb_wr_valid !== 1'b0 || pixel_cnt !== 20'd2) begin
      errors++; $display("FAIL edge_nopush got fbv=%b cnt=%0d want 0 2", fb_wr_valid, pixel_cnt); end
  endtask

  task automatic test_backpressure();
    ray_t r25;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, mk(20'(20 + i), 16'd0, 16'd0, 16'd0, 6'd1, 1'b1, 4'd1, 3'd1), 0);
    r25 = mk(20'd25, 16'd0, 16'd0, 16'd0, 6'd1, 1'b1, 4'd1, 3'd1);
    cyc(1, r25, 0);
    checks++; if ({stall, next_en, ray_valid_out, fb_wr_valid, fb_wr_addr, pixel_cnt} !== {4'b1001, 20'd20, 20'd4}) begin
      errors++; $display("FAIL bp_stall got stall=%b next_en=%b head=%0d cnt=%0d want 1 0 20 4",
                          stall, next_en, fb_wr_addr, pixel_cnt); end
    cyc(1, r25, 0);
    checks++; if (stall !== 1'b1 || pixel_cnt !== 20'd4) begin
      errors++; $display("FAIL bp_hold got stall=%b cnt=%0d want 1 4", stall, pixel_cnt); end
    cyc(1, r25, 1);
    checks++; if ({stall, next_en, fb_wr_addr} !== {2'b01, 20'd20}) begin
      errors++; $display("FAIL bp_release got stall=%b next_en=%b head=%0d want 0 1 20", stall, next_en, fb_wr_addr); end
    cyc(0, '0, 0);
    checks++; if ({stall, fb_wr_addr, pixel_cnt} !== {1'b1, 20'd21, 20'd5}) begin
      errors++; $display("FAIL bp_refull got stall=%b head=%0d cnt=%0d want 1 21 5", stall, fb_wr_addr, pixel_cnt); end
    for (int i = 21; i <= 25; i++) begin
      cyc(0, '0, 1);
      checks++; if ({fb_wr_valid, fb_wr_addr} !== {1'b1, 20'(i)}) begin
        errors++; $display("FAIL bp_order got v=%b addr=%0d want 1 %0d", fb_wr_valid, fb_wr_addr, i); end
    end
    cyc(0, '0, 1);
    checks++; if (fb_wr_valid !== 1'b0 || pixel_cnt !== 20'd6) begin
      errors++; $display("FAIL bp_empty got fbv=%b cnt=%0d want 0 6", fb_wr_valid, pixel_cnt); end
  endtask

  task automatic test_frame_wrap();
    int fd = 0, fd_at = -1;
    do_reset();
    for (int i = 0; i < FRAME + 2; i++) begin
      cyc(i < FRAME, mk(20'(i), 16'd0, 16'd0, 16'd0, 6'd2, 1'b1, 4'd5, 3'd4), 1);
      if (frame_done === 1'b1) begin
        fd++; fd_at = i;
        checks++; if (pixel_cnt !== 20'(FRAME - 1)) begin
          errors++; $display("FAIL wrap_at got cnt=%0d want %0d", pixel_cnt, FRAME - 1); end
      end
    end
    checks++; if (fd !== 1 || fd_at !== FRAME) begin
      errors++; $display("FAIL wrap_pulse got %0d pulses at %0d want 1 at %0d", fd, fd_at, FRAME); end
    checks++; if (pixel_cnt !== 20'd0) begin
      errors++; $display("FAIL wrap_cnt got %0d want 0", pixel_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, mk(20'(40 + i), 16'd0, 16'd0, 16'd0, 6'd3, 1'b1, 4'd2, 3'd3), 0);
    cyc(0, '0, 0);
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL mr_full got stall=%b want 1", stall); end
    do_reset();
    checks++; if ({fb_wr_valid, stall, ray_valid_out, next_en, pixel_cnt} !== {4'b0001, 20'd0}) begin
      errors++; $display("FAIL mr_clear got fbv=%b stall=%b rvo=%b next_en=%b cnt=%0d want 0 0 0 1 0",
                          fb_wr_valid, stall, ray_valid_out, next_en, pixel_cnt); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1);
      checks++; if (fb_wr_valid !== 1'b0) begin
        errors++; $display("FAIL mr_nowrite cycle %0d got fbv=%b want 0", i, fb_wr_valid); end
    end
  endtask

  task automatic test_random();
    logic v = 0, rdy, e_ret, e_pop, e_stl, e_rvo, e_fd;
    ray_t r = '0;
    bit prev_stall = 0;
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      if (!prev_stall) begin
        v = ($urandom_range(0, 9) < 7);
        r = rnd_ray();
      end
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      cyc(v, r, rdy);
      e_ret = m_slot_v && retires(m_slot);
      e_pop = (m_q.size() > 0) && rdy;
      e_stl = e_ret && (m_q.size() == DEPTH) && !e_pop;
      e_rvo = m_slot_v && !e_ret;
      e_fd  = e_ret && !e_stl && (m_pcnt == FRAME - 1);
      checks++; if ({stall, next_en, ray_valid_out, fb_wr_valid, frame_done}
                    !== {e_stl, !e_stl && !e_rvo, e_rvo, m_q.size() > 0, e_fd}) begin
        errors++; $display("FAIL rnd_ctrl cycle %0d got %b want %b", i,
                            {stall, next_en, ray_valid_out, fb_wr_valid, frame_done},
                            {e_stl, !e_stl && !e_rvo, e_rvo, m_q.size() > 0, e_fd}); end
      checks++; if (pixel_cnt !== 20'(m_pcnt)) begin
        errors++; $display("FAIL rnd_pcnt cycle %0d got %0d want %0d", i, pixel_cnt, m_pcnt); end
      if (m_q.size() > 0) begin
        checks++; if ({fb_wr_addr, fb_wr_data} !== m_q[0]) begin
          errors++; $display("FAIL rnd_fb cycle %0d got %h want %h", i, {fb_wr_addr, fb_wr_data}, m_q[0]); end
      end
      if (e_rvo) begin
        checks++; if ({pixel_addr_out, end_pos_x, end_pos_y, end_pos_z, ray_slope_out_x, ray_slope_out_y,
                       ray_slope_out_z, block_cnt_out} !== {m_slot.addr, m_slot.px, m_slot.py, m_slot.pz,
                       m_slot.sx, m_slot.sy, m_slot.sz, m_slot.cnt + 6'd1}) begin
          errors++; $display("FAIL rnd_ray cycle %0d got addr=%h cnt=%0d want addr=%h cnt=%0d", i,
                              pixel_addr_out, block_cnt_out, m_slot.addr, m_slot.cnt + 6'd1); end
      end
      model_step(v, r, rdy);
      prev_stall = e_stl;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; fb_wr_ready = 1'b0;
    in_pixel_addr = '0; in_pos_x = '0; in_pos_y = '0; in_pos_z = '0;
    in_slope_x = '0; in_slope_y = '0; in_slope_z = '0;
    in_block_cnt = '0; in_hit = 1'b0; in_block_id = '0; in_face = '0;
    test_reset();
    test_hit();
    test_recirc();
    test_limits();
    test_backpressure();
    test_frame_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
